fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 10, program counter width in bits.
REQ-002 SHALL have parameter LUT_AW, default 5, branch lookup table address width (2^LUT_AW entries of PC_W bits).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level-sampled request to begin a program run at address 0.
REQ-006 SHALL have port instr_done  input  1  decoder flag, current instruction is DONE.
REQ-007 SHALL have port doBranch  input  1  ALU branch-taken flag for current instruction.
REQ-008 SHALL have port branch_rel  input  1  1 = relative branch (BEQ/B), 0 = table branch (B_LOOKUP).
REQ-009 SHALL have port branch_off  input  8  signed two's-complement relative offset.
REQ-010 SHALL have port lut_idx  input  LUT_AW  table entry selected for a table branch.
REQ-011 SHALL have ports lut_we (input, 1), lut_waddr (input, LUT_AW) and lut_wdata (input, PC_W): table write port.
REQ-012 SHALL have port prog_ctr  output  PC_W  address of the instruction executing this cycle.
REQ-013 SHALL have ports running (output, 1), set in RUN, and done (output, 1), set in HALT.
REQ-014 SHALL have port cycle_cnt  output  16  count of RUN cycles in the current or last run.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, HALT; all outputs registered.
REQ-016 IDLE: start=1 -> RUN next cycle with prog_ctr=0 and cycle_cnt=0; otherwise hold.
REQ-017 RUN, instr_done=1 -> HALT next cycle, prog_ctr held; instr_done overrides doBranch in the same cycle.
REQ-018 RUN, instr_done=0 and doBranch=1 and branch_rel=1 -> prog_ctr <= prog_ctr + sign-extended branch_off, modulo 2^PC_W.
REQ-019 RUN, instr_done=0 and doBranch=1 and branch_rel=0 -> prog_ctr <= table entry lut_idx.
REQ-020 RUN, instr_done=0 and doBranch=0 -> prog_ctr <= prog_ctr + 1; all-ones wraps to 0.
REQ-021 RUN ignores start.
REQ-022 HALT: done=1 and prog_ctr held; start=1 -> RUN next cycle with prog_ctr=0, done=0, cycle_cnt=0.
REQ-023 Branch target is one cycle latency: value visible on prog_ctr the cycle after doBranch sampled.
REQ-024 lut_we=1 writes lut_wdata to entry lut_waddr at the edge, in any state.
REQ-025 Write and table-branch read of the same entry in one cycle SHALL use the old entry value.
REQ-026 cycle_cnt SHALL increment once per RUN cycle, saturate at 0xFFFF, and hold in HALT and IDLE.

Reset
REQ-027 reset=1 at an edge SHALL force IDLE, prog_ctr=0, running=0, done=0, cycle_cnt=0, regardless of state or other inputs.
REQ-028 Reset mid-run SHALL abandon the run; a new start is required.
REQ-029 Table contents SHALL be unaffected by reset.

Configuration
REQ-030 Macro FETCH_CYCLE_COUNT_EN defined: cycle_cnt counter SHALL be built per REQ-026.
REQ-031 Macro FETCH_CYCLE_COUNT_EN undefined: cycle_cnt SHALL be constant 0 with no counter logic; all other behaviour unchanged.

Verification
REQ-032 Reset, start=1 one cycle, no branches -> prog_ctr 0,1,2,3 on successive cycles; running=1.
REQ-033 At prog_ctr=5, doBranch=1, branch_rel=1, branch_off=0xFD -> next prog_ctr=2; at prog_ctr=0, branch_off=0xFF -> next prog_ctr=0x3FF.
REQ-034 Write lut[3]=0x120, then at prog_ctr=7 doBranch=1, branch_rel=0, lut_idx=3 -> next prog_ctr=0x120; same-cycle write of lut[3]=0x050 -> jump to 0x120.
REQ-035 instr_done=1 and doBranch=1 at prog_ctr=9 after 10 RUN cycles -> HALT, done=1, prog_ctr=9, cycle_cnt=10 (0 without macro); start -> prog_ctr=0, done=0.
REQ-036 reset=1 during RUN at prog_ctr=0x44 -> next cycle IDLE, all outputs 0; previously written table entries still returned on later table branch.

Source files
------------

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if -- bundle of the fetch controller's control, branch, table-write
// and status signals. clk and reset stay plain ports on the module itself.
//
// Signals (directions seen from the slave, i.e. the fetch controller):
//   start       in   level-sampled request to begin a run at address 0
//   instr_done  in   current instruction is DONE
//   doBranch    in   branch taken for the current instruction
//   branch_rel  in   1 = relative branch, 0 = table branch
//   branch_off  in   signed 8-bit relative offset
//   lut_idx     in   table entry used by a table branch
//   lut_we      in   table write enable
//   lut_waddr   in   table write address
//   lut_wdata   in   table write data
//   prog_ctr    out  address of the instruction executing this cycle
//   running     out  high while in RUN
//   done        out  high while in HALT
//   cycle_cnt   out  RUN cycles in the current or last run
interface fetch_ctrl_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5
);
    logic                    start;
    logic                    instr_done;
    logic                    doBranch;
    logic                    branch_rel;
    logic signed [7:0]       branch_off;
    logic [LUT_AW-1:0]       lut_idx;
    logic                    lut_we;
    logic [LUT_AW-1:0]       lut_waddr;
    logic [PC_W-1:0]         lut_wdata;
    logic [PC_W-1:0]         prog_ctr;
    logic                    running;
    logic                    done;
    logic [15:0]             cycle_cnt;

    modport master (
        output start, instr_done, doBranch, branch_rel, branch_off, lut_idx,
               lut_we, lut_waddr, lut_wdata,
        input  prog_ctr, running, done, cycle_cnt
    );

    modport slave (
        input  start, instr_done, doBranch, branch_rel, branch_off, lut_idx,
               lut_we, lut_waddr, lut_wdata,
        output prog_ctr, running, done, cycle_cnt
    );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- program counter sequencer with IDLE/RUN/HALT control, relative
// and table-driven branches, and an optional RUN-cycle counter.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous active-high reset (table contents are kept)
//   bus    fetch_ctrl_if.slave (see rtl/fetch_ctrl_if.sv for signal list)
//
// Build option: define FETCH_CYCLE_COUNT_EN to build the saturating 16-bit
// cycle_cnt counter; without it cycle_cnt is tied to 0.
module fetch_ctrl #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            running_r;
    logic            done_r;

    // Branch table; deliberately not reset so entries survive a reset.
    logic [PC_W-1:0] lut [2**LUT_AW];

    // Relative target: sign-extend the 8-bit offset to PC_W and add modulo 2^PC_W.
    function automatic logic [PC_W-1:0] rel_target(input logic [PC_W-1:0] pc_in,
                                                   input logic signed [7:0] off);
        logic signed [PC_W-1:0] ext;
        ext = PC_W'(off);
        return pc_in + ext;
    endfunction

    // Table write; a same-edge table-branch read sees the old entry because
    // both sides are updated non-blocking at the same edge.
    always_ff @(posedge clk) begin
        if (bus.lut_we)
            lut[bus.lut_waddr] <= bus.lut_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (bus.start) begin
                        state     <= RUN;
                        pc        <= '0;
                        running_r <= 1'b1;
                        done_r    <= 1'b0;
                    end
                end
                RUN: begin
                    // instr_done wins over any branch in the same cycle.
                    if (bus.instr_done) begin
                        state     <= HALT;
                        running_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else if (bus.doBranch) begin
                        pc <= bus.branch_rel ? rel_target(pc, bus.branch_off)
                                             : lut[bus.lut_idx];
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    pc        <= '0;
                    running_r <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prog_ctr = pc;
    assign bus.running  = running_r;
    assign bus.done     = done_r;

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (state != RUN && bus.start)
            cnt <= '0;
        else if (state == RUN)
            cnt <= sat_inc(cnt);
    end

    assign bus.cycle_cnt = cnt;
`else
    assign bus.cycle_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- directed bench for fetch_ctrl with a reference model feeding
// a scoreboard queue, plus fixed-value checks of the key program-counter values.
module tb_fetch_ctrl;
    localparam int PC_W   = 10;
    localparam int LUT_AW = 5;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            run;
        logic            done;
        logic [15:0]     cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // Reference model state
    int              m_st;     // 0 idle, 1 run, 2 halt
    logic [PC_W-1:0] m_pc;
    logic            m_run;
    logic            m_done;
    logic [15:0]     m_cnt;
    logic [PC_W-1:0] m_lut [32];

    fetch_ctrl_if #(.PC_W(PC_W), .LUT_AW(LUT_AW)) bus ();

    fetch_ctrl #(.PC_W(PC_W), .LUT_AW(LUT_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model with the currently driven inputs, push the expectation,
    // clock the DUT and compare once the outputs have settled.
    task automatic tick(input bit check = 1'b1);
        exp_t e;
        exp_t g;
        logic [PC_W-1:0] rd;
        rd = m_lut[bus.lut_idx];
        if (reset) begin
            m_st = 0; m_pc = '0; m_run = 0; m_done = 0; m_cnt = '0;
        end else if (m_st != 1) begin
            if (bus.start) begin
                m_st = 1; m_pc = '0; m_run = 1; m_done = 0; m_cnt = '0;
            end
        end else begin
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (bus.instr_done) begin
                m_st = 2; m_run = 0; m_done = 1;
            end else if (bus.doBranch) begin
                if (bus.branch_rel)
                    m_pc = m_pc + {{2{bus.branch_off[7]}}, bus.branch_off};
                else
                    m_pc = rd;
            end else begin
                m_pc = m_pc + 10'd1;
            end
        end
        if (bus.lut_we) m_lut[bus.lut_waddr] = bus.lut_wdata;
        e.pc = m_pc; e.run = m_run; e.done = m_done;
`ifdef FETCH_CYCLE_COUNT_EN
        e.cnt = m_cnt;
`else
        e.cnt = 16'd0;
`endif
        if (check) sb.push_back(e);
        @(posedge clk);
        #1;
        if (check) begin
            g = sb.pop_front();
            chk("prog_ctr",  32'(bus.prog_ctr),  32'(g.pc));
            chk("running",   32'(bus.running),   32'(g.run));
            chk("done",      32'(bus.done),      32'(g.done));
            chk("cycle_cnt", 32'(bus.cycle_cnt), 32'(g.cnt));
        end
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.instr_done = 0; bus.doBranch = 0; bus.branch_rel = 0;
        bus.branch_off = '0; bus.lut_idx = '0; bus.lut_we = 0; bus.lut_waddr = '0;
        bus.lut_wdata = '0;
    endtask

    initial begin
        m_st = 0; m_pc = '0; m_run = 0; m_done = 0; m_cnt = '0;
        for (int i = 0; i < 32; i++) m_lut[i] = '0;
        idle_inputs();
        bus.start = 1;        // reset must override a pending start
        reset = 1;
        #2;
        tick(); tick();
        chk("reset_pc", 32'(bus.prog_ctr), 32'h0);
        reset = 0;
        bus.start = 0;

        // Preload table entries while idle.
        bus.lut_we = 1; bus.lut_waddr = 5'd3; bus.lut_wdata = 10'h120; tick();
        bus.lut_waddr = 5'd7; bus.lut_wdata = 10'h0AB; tick();
        bus.lut_we = 0;
        chk("idle_running", 32'(bus.running), 32'h0);

        // Start, then sequential fetch 0,1,2,3,4,5.
        bus.start = 1; tick();
        chk("start_pc0", 32'(bus.prog_ctr), 32'h0);
        bus.start = 0;
        for (int i = 1; i <= 5; i++) tick();
        chk("seq_pc5", 32'(bus.prog_ctr), 32'h5);

        // Relative branches: backward, to zero, and underflow to all-ones.
        bus.doBranch = 1; bus.branch_rel = 1; bus.branch_off = 8'shFD; tick();
        chk("rel_back", 32'(bus.prog_ctr), 32'h2);
        bus.branch_off = 8'shFE; tick();
        chk("rel_zero", 32'(bus.prog_ctr), 32'h0);
        bus.branch_off = 8'shFF; tick();
        chk("rel_wrap", 32'(bus.prog_ctr), 32'h3FF);
        bus.doBranch = 0; tick();
        chk("inc_wrap", 32'(bus.prog_ctr), 32'h0);
        for (int i = 1; i <= 7; i++) tick();

        // Table branch at pc 7 with a same-cycle write to the same entry.
        bus.doBranch = 1; bus.branch_rel = 0; bus.lut_idx = 5'd3;
        bus.lut_we = 1; bus.lut_waddr = 5'd3; bus.lut_wdata = 10'h050; tick();
        chk("lut_old", 32'(bus.prog_ctr), 32'h120);
        bus.lut_we = 0; tick();
        chk("lut_new", 32'(bus.prog_ctr), 32'h050);

        // start during RUN is ignored.
        bus.doBranch = 0; bus.start = 1; tick();
        chk("run_ign_start", 32'(bus.prog_ctr), 32'h051);
        bus.start = 0;

        // Halt, restart, run ten cycles, halt with a competing branch.
        bus.instr_done = 1; tick();
        bus.instr_done = 0; tick();
        chk("halt_hold", 32'(bus.prog_ctr), 32'h051);
        bus.start = 1; tick();
        bus.start = 0;
        for (int i = 1; i <= 9; i++) tick();
        bus.instr_done = 1; bus.doBranch = 1; bus.branch_rel = 1; bus.branch_off = 8'sh10; tick();
        chk("halt_pc", 32'(bus.prog_ctr), 32'h9);
        chk("halt_done", 32'(bus.done), 32'h1);
`ifdef FETCH_CYCLE_COUNT_EN
        chk("halt_cnt", 32'(bus.cycle_cnt), 32'd10);
`else
        chk("halt_cnt", 32'(bus.cycle_cnt), 32'd0);
`endif
        bus.instr_done = 0; bus.doBranch = 0; tick();
        bus.start = 1; tick();
        chk("restart_pc", 32'(bus.prog_ctr), 32'h0);
        chk("restart_done", 32'(bus.done), 32'h0);
        bus.start = 0;

        // Reset mid-run at pc 0x44; table survives.
        bus.doBranch = 1; bus.branch_rel = 1; bus.branch_off = 8'sh44; tick();
        chk("pc_44", 32'(bus.prog_ctr), 32'h44);
        bus.doBranch = 0; reset = 1; tick();
        chk("rst_run", 32'(bus.running), 32'h0);
        reset = 0; tick(); tick();
        chk("rst_stays_idle", 32'(bus.running), 32'h0);
        bus.start = 1; tick();
        bus.start = 0; bus.doBranch = 1; bus.branch_rel = 0; bus.lut_idx = 5'd7; tick();
        chk("lut_after_rst", 32'(bus.prog_ctr), 32'h0AB);
        bus.lut_idx = 5'd3; tick();
        chk("lut3_after_rst", 32'(bus.prog_ctr), 32'h050);
        bus.doBranch = 0;

`ifdef FETCH_CYCLE_COUNT_EN
        // Counter saturation: run long enough to pass 0xFFFF.
        for (int i = 0; i < 65540; i++) tick(1'b0);
        tick();
        chk("cnt_sat", 32'(bus.cycle_cnt), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
